// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported 1024x32 memory between the instruction
// fetch port (I, read-only) and the data port (D, read/write). Each granted
// access runs IDLE -> ACCESS -> DONE, so one transaction completes every three
// cycles. Simultaneous requests are resolved round-robin.
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_add,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_add,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          busy,
  output logic          mem_reset,
  output logic          mem_enable,
  output logic          mem_rw,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_wData,
  input  logic [DW-1:0] mem_rData
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_d;
  logic          grant_d;
  logic          owner_d;
  logic [DW-1:0] i_hold;
  logic [DW-1:0] d_hold;

  // The memory reloads its boot program whenever the system is held in reset.
  assign mem_reset = !reset;

  // Pick the winner for IDLE: a lone requester wins, a conflict goes to the
  // port that was not granted last.
  always_comb begin
    grant_d = 1'b0;
    if (d_req && !i_req) begin
      grant_d = 1'b1;
    end else if (d_req && i_req) begin
      grant_d = !last_d;
    end
  end

  // Next-state logic: leave IDLE on any request, then step through unconditionally.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_req || d_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the winner's request at the grant, pulse the enable for ACCESS, and
  // capture read data into the owner's hold register on leaving DONE. The I
  // port has no write data, so an I grant leaves mem_wData untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d     <= 1'b1;
      owner_d    <= 1'b0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b0;
      mem_add    <= '0;
      mem_wData  <= '0;
      i_hold     <= '0;
      d_hold     <= '0;
    end else begin
      mem_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d    <= grant_d;
            last_d     <= grant_d;
            mem_enable <= 1'b1;
            if (grant_d) begin
              mem_add   <= d_add;
              mem_rw    <= d_rw;
              mem_wData <= d_wdata;
            end else begin
              mem_add <= i_add;
              mem_rw  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!mem_rw) begin
            if (owner_d) begin
              d_hold <= mem_rData;
            end else begin
              i_hold <= mem_rData;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Acks and read data: DONE forwards the memory output to the owning port on
  // a read; every other cycle shows the held value.
  always_comb begin
    busy    = (state != IDLE);
    i_ack   = (state == DONE) && !owner_d;
    d_ack   = (state == DONE) && owner_d;
    i_rdata = i_hold;
    d_rdata = d_hold;
    if (i_ack && !mem_rw) begin
      i_rdata = mem_rData;
    end
    if (d_ack && !mem_rw) begin
      d_rdata = mem_rData;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter against a behavioural memory and checks
// every cycle against a transaction-level reference model, with directed
// scenarios followed by a randomized run.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_add;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_add;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          busy;
  logic          mem_reset;
  logic          mem_enable;
  logic          mem_rw;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wData;
  logic [DW-1:0] mem_rData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_add(i_add), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_add(d_add), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
    .mem_reset(mem_reset), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_add(mem_add), .mem_wData(mem_wData), .mem_rData(mem_rData)
  );

  // Boot image of the memory: a few fixed program words, a recognisable fill elsewhere.
  function automatic logic [31:0] progWord(input int a);
    case (a)
      0:       return 32'h6810_0000;
      1:       return 32'h0000_0C00;
      2:       return 32'h8000_0800;
      5:       return 32'h0000_0800;
      8:       return 32'h5900_2000;
      default: return 32'hA500_0000 | 32'(a);
    endcase
  endfunction

  // Behavioural single-ported memory with registered read data and program reload on reset.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= progWord(i);
      mem_rData <= '0;
    end else if (mem_enable) begin
      if (mem_rw) mem[mem_add] <= mem_wData;
      else mem_rData <= mem[mem_add];
    end
  end

  // Reference model: one outstanding transaction with its age in cycles
  // (0 = none, 1 = memory cycle, 2 = ack cycle) plus the expected memory image.
  int          mAge;
  bit          mOwnerD;
  bit          mLastD;
  bit          mRw;
  logic [9:0]  mAddr;
  logic [31:0] mWData;
  logic [31:0] mIHold;
  logic [31:0] mDHold;
  logic [31:0] refMem [0:1023];
  bit          expIAck;
  bit          expDAck;

  task automatic modelEdge();
    if (!reset) begin
      mAge = 0; mLastD = 1'b1; mOwnerD = 1'b0; mRw = 1'b0;
      mAddr = '0; mWData = '0; mIHold = '0; mDHold = '0;
      for (int i = 0; i < 1024; i++) refMem[i] = progWord(i);
    end else if (mAge == 0) begin
      if (i_req || d_req) begin
        mOwnerD = (i_req && d_req) ? !mLastD : d_req;
        mLastD  = mOwnerD;
        if (mOwnerD) begin
          mAddr = d_add; mRw = d_rw; mWData = d_wdata;
        end else begin
          mAddr = i_add; mRw = 1'b0;
        end
        mAge = 1;
      end
    end else if (mAge == 1) begin
      if (mRw) refMem[mAddr] = mWData;
      mAge = 2;
    end else begin
      if (!mRw) begin
        if (mOwnerD) mDHold = refMem[mAddr];
        else mIHold = refMem[mAddr];
      end
      mAge = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic verifyCycle();
    logic [31:0] expIR;
    logic [31:0] expDR;
    expIAck = (mAge == 2) && !mOwnerD;
    expDAck = (mAge == 2) && mOwnerD;
    expIR = (expIAck && !mRw) ? refMem[mAddr] : mIHold;
    expDR = (expDAck && !mRw) ? refMem[mAddr] : mDHold;
    checkOutput("busy", 32'(busy), 32'(mAge != 0));
    checkOutput("mem_enable", 32'(mem_enable), 32'(mAge == 1));
    checkOutput("mem_reset", 32'(mem_reset), 32'(!reset));
    checkOutput("mem_add", 32'(mem_add), 32'(mAddr));
    checkOutput("mem_rw", 32'(mem_rw), 32'(mRw));
    checkOutput("mem_wData", mem_wData, mWData);
    checkOutput("i_ack", 32'(i_ack), 32'(expIAck));
    checkOutput("d_ack", 32'(d_ack), 32'(expDAck));
    checkOutput("i_rdata", i_rdata, expIR);
    checkOutput("d_rdata", d_rdata, expDR);
  endtask

  // Drive one cycle of inputs, advance past the edge, then compare against the model.
  task automatic applyStimulus(input bit ir, input int ia, input bit dr, input bit drw,
                               input int da, input logic [31:0] dwd, input bit rstn);
    i_req = ir; i_add = 10'(ia); d_req = dr; d_rw = drw; d_add = 10'(da);
    d_wdata = dwd; reset = rstn;
    @(posedge clk);
    modelEdge();
    #1;
    verifyCycle();
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);
  endtask

  initial begin
    bit rI, rD, rRw, rRst;
    int rIA, rDA;
    logic [31:0] rWd;

    // Reset for two cycles.
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_i_rdata", i_rdata, 32'h0);

    // I read of address 0.
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 1);
    checkOutput("iread_enable", 32'(mem_enable), 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 1);
    checkOutput("iread_ack", 32'(i_ack), 32'h1);
    checkOutput("iread_data", i_rdata, 32'h6810_0000);
    idleStep();
    checkOutput("iread_hold", i_rdata, 32'h6810_0000);

    // D write then read back at the top address.
    applyStimulus(0, 0, 1, 1, 10'h3FF, 32'hDEAD_BEEF, 1);
    applyStimulus(0, 0, 1, 1, 10'h3FF, 32'hDEAD_BEEF, 1);
    checkOutput("dwrite_ack", 32'(d_ack), 32'h1);
    checkOutput("dwrite_rdata", d_rdata, 32'h0);
    idleStep();
    applyStimulus(0, 0, 1, 0, 10'h3FF, 32'h0, 1);
    applyStimulus(0, 0, 1, 0, 10'h3FF, 32'h0, 1);
    checkOutput("dread_data", d_rdata, 32'hDEAD_BEEF);
    idleStep();

    // Contention: I first, D three cycles later, then I again.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 1, 1, 0, 2, 32'h0, 1);
      if (k == 2) begin
        checkOutput("rr_i_first", 32'(i_ack), 32'h1);
        checkOutput("rr_i_data", i_rdata, 32'h0000_0C00);
      end
      if (k == 5) begin
        checkOutput("rr_d_second", 32'(d_ack), 32'h1);
        checkOutput("rr_d_data", d_rdata, 32'h8000_0800);
      end
      if (k == 8) checkOutput("rr_i_third", 32'(i_ack), 32'h1);
    end
    idleStep();

    // D alone, held for nine cycles: acks at cycles 2, 5 and 8.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 0, 1, 0, 2, 32'h0, 1);
      checkOutput("dheld_ack", 32'(d_ack), 32'(((k + 1) % 3) == 2));
      checkOutput("dheld_no_iack", 32'(i_ack), 32'h0);
    end
    idleStep();

    // Reset during ACCESS of a write to address 8 aborts it.
    applyStimulus(0, 0, 1, 1, 8, 32'h1234_5678, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("abort_no_ack", 32'(d_ack), 32'h0);
    checkOutput("abort_idle", 32'(busy), 32'h0);
    applyStimulus(0, 0, 1, 0, 8, 32'h0, 1);
    applyStimulus(0, 0, 1, 0, 8, 32'h0, 1);
    checkOutput("abort_reload", d_rdata, 32'h5900_2000);
    idleStep();

    // Address change during ACCESS is ignored.
    applyStimulus(0, 0, 1, 0, 5, 32'h0, 1);
    checkOutput("latch_addr", 32'(mem_add), 32'h5);
    applyStimulus(0, 0, 1, 0, 6, 32'h0, 1);
    checkOutput("latch_data", d_rdata, 32'h0000_0800);
    idleStep();

    // Randomized traffic with occasional resets.
    rI = 0; rD = 0; rRw = 0;
    for (int n = 0; n < 1500; n++) begin
      if (rI && expIAck) rI = ($urandom_range(0, 3) == 0);
      else if (!rI) rI = ($urandom_range(0, 2) == 0);
      if (rD && expDAck) rD = ($urandom_range(0, 3) == 0);
      else if (!rD) begin
        rD = ($urandom_range(0, 2) == 0);
        rRw = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 9) == 0) rRw = $urandom_range(0, 1);
      rIA = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 15);
      rDA = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 15);
      rWd = $urandom;
      rRst = ($urandom_range(0, 79) != 0);
      applyStimulus(rI, rIA, rD, rRw, rDA, rWd, rRst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
